// File: rtl/axi_stream_interconnect_m2s_head_rr.sv
// Packet round-robin merge of NUM AXI-Stream sources into one stream,
// prepending a HEAD_DUMMY-beat route header (last beat = source index).
//
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   s_tvalid/tdata/tlast     NUM upstream sources (source i at [i*DSIZE +: DSIZE])
//   s_tready                 per-source ready, only the granted source in BODY
//   m_tvalid/tdata/tlast     merged downstream stream
//   m_tready                 downstream ready
//   cur_grant                source owning the link (held after the packet)
//   busy                     high while a header or body is in flight
module axi_stream_interconnect_m2s_head_rr #(
    parameter int DSIZE      = 8,
    parameter int NUM        = 4,
    parameter int HEAD_DUMMY = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM-1:0]         s_tvalid,
    input  logic [NUM*DSIZE-1:0]   s_tdata,
    input  logic [NUM-1:0]         s_tlast,
    output logic [NUM-1:0]         s_tready,
    output logic                   m_tvalid,
    output logic [DSIZE-1:0]       m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [$clog2(NUM)-1:0] cur_grant,
    output logic                   busy
);

    localparam int GW = $clog2(NUM);
    localparam int HW = $clog2(HEAD_DUMMY + 1);

    localparam logic [HW-1:0] HLAST = HW'(HEAD_DUMMY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hcnt;
    logic [HW-1:0]   hcnt_nxt;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   grant_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   last_nxt;

    logic            rr_found;
    logic [GW-1:0]   rr_win;
    logic [GW-1:0]   cand;

    logic            sel_valid;
    logic [DSIZE-1:0] sel_data;
    logic            sel_last;
    logic [DSIZE-1:0] grant_ext;

    // Granted-source view used by the BODY pass-through.
    assign sel_valid = s_tvalid[grant];
    assign sel_data  = s_tdata[int'(grant)*DSIZE +: DSIZE];
    assign sel_last  = s_tlast[grant];

    assign cur_grant = grant;
    assign busy      = (state != IDLE);

    always_comb begin
        grant_ext         = '0;
        grant_ext[GW-1:0] = grant;
    end

    // Search starts one past the previous winner, so the first valid
    // source in that rotated order wins.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 0; k < NUM; k++) begin
            cand = GW'((int'(last_grant) + 1 + k) % NUM);
            if (!rr_found && s_tvalid[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    // State and control registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            hcnt       <= '0;
            grant      <= '0;
            last_grant <= GW'(NUM - 1);
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            grant      <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        grant_nxt = grant;
        last_nxt  = last_grant;
        unique case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_win;
                    hcnt_nxt  = '0;
                    state_nxt = HEAD;
                end
            end
            HEAD: begin
                // m_tvalid is always high here, so ready alone is a handshake.
                if (m_tready) begin
                    hcnt_nxt = hcnt + HW'(1);
                    if (hcnt == HLAST) begin
                        state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                if (sel_valid && m_tready && sel_last) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        unique case (state)
            IDLE: begin
                m_tvalid = 1'b0;
            end
            HEAD: begin
                m_tvalid = 1'b1;
                if (hcnt == HLAST) begin
                    m_tdata = grant_ext;
                end
            end
            BODY: begin
                m_tvalid        = sel_valid;
                m_tdata         = sel_data;
                m_tlast         = sel_last;
                s_tready[grant] = m_tready;
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_stream_interconnect_m2s_head_rr.sv
// Bench for axi_stream_interconnect_m2s_head_rr: directed packets,
// scoreboard of expected downstream beats, immediate assertions.
module tb_axi_stream_interconnect_m2s_head_rr;

    localparam int DSIZE = 8;
    localparam int NUM   = 4;
    localparam int HD    = 4;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b0;
    logic [NUM-1:0]         s_tvalid = '0;
    logic [NUM*DSIZE-1:0]   s_tdata = '0;
    logic [NUM-1:0]         s_tlast = '0;
    logic [NUM-1:0]         s_tready;
    logic                   m_tvalid;
    logic [DSIZE-1:0]       m_tdata;
    logic                   m_tlast;
    logic                   m_tready = 1'b1;
    logic [1:0]             cur_grant;
    logic                   busy;

    logic [1:0]             s1_tvalid = '0;
    logic [15:0]            s1_tdata = '0;
    logic [1:0]             s1_tlast = '0;
    logic [1:0]             s1_tready;
    logic                   m1_tvalid;
    logic [7:0]             m1_tdata;
    logic                   m1_tlast;
    logic                   m1_tready = 1'b1;
    logic [0:0]             cur_grant1;
    logic                   busy1;

    always #5 aclk = ~aclk;

    axi_stream_interconnect_m2s_head_rr #(
        .DSIZE(DSIZE), .NUM(NUM), .HEAD_DUMMY(HD)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .cur_grant(cur_grant), .busy(busy)
    );

    axi_stream_interconnect_m2s_head_rr #(
        .DSIZE(8), .NUM(2), .HEAD_DUMMY(1)
    ) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s1_tvalid), .s_tdata(s1_tdata), .s_tlast(s1_tlast),
        .s_tready(s1_tready),
        .m_tvalid(m1_tvalid), .m_tdata(m1_tdata), .m_tlast(m1_tlast),
        .m_tready(m1_tready),
        .cur_grant(cur_grant1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       hdr;
        int         src;
    } beat_t;

    beat_t          exp_q[$];
    logic [8:0]     src_q[NUM][$];
    logic [NUM-1:0] hold = '0;
    logic [NUM-1:0] fire_s = '0;

    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   busy_cnt = 0;
    int   t_first = 0;
    int   t_last = 0;
    bit   first_seen = 1'b0;
    bit   gap_chk = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a packet at a source and its expected downstream image.
    task automatic send_pkt(input int src, input int n, input logic [7:0] base);
        beat_t e;
        logic [7:0] d;
        for (int h = 0; h < HD; h++) begin
            e.d   = (h == HD - 1) ? 8'(src) : 8'h00;
            e.l   = 1'b0;
            e.hdr = 1'b1;
            e.src = src;
            exp_q.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            d     = base + 8'(b);
            e.d   = d;
            e.l   = (b == n - 1);
            e.hdr = 1'b0;
            e.src = src;
            src_q[src].push_back({e.l, d});
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int maxc);
        for (int c = 0; c < maxc && exp_q.size() > 0; c++) begin
            @(posedge aclk);
            #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_sz(input int n, input int maxc, input string tag);
        for (int c = 0; c < maxc; c++) begin
            if (exp_q.size() == n) break;
            @(posedge aclk);
            #1;
        end
        chk(tag, exp_q.size(), n);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        hold = '0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // Source models: consume on handshake, present next beat unless held.
    always @(posedge aclk) begin
        logic [8:0] t;
        #2;
        for (int i = 0; i < NUM; i++) begin
            if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        fire_s = '0;
        for (int i = 0; i < NUM; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                t = src_q[i][0];
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DSIZE +: DSIZE] = t[7:0];
                s_tlast[i]           = t[8];
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DSIZE +: DSIZE] = '0;
                s_tlast[i]           = 1'b0;
            end
        end
    end

    // Downstream monitor and scoreboard.
    always @(negedge aclk) begin
        beat_t e;
        logic [NUM-1:0] er;
        ncyc++;
        if (!aresetn) begin
            prev_stall = 1'b0;
            gap_chk    = 1'b0;
            fire_s     = '0;
        end else begin
            fire_s = s_tvalid & s_tready;
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, prev_d);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            if (gap_chk) chk("gap_idle", busy, 0);
            gap_chk = 1'b0;
            if (busy) busy_cnt++;
            if (busy && exp_q.size() > 0) begin
                e  = exp_q[0];
                er = '0;
                if (!e.hdr) er[e.src] = m_tready;
                chk("s_tready", s_tready, er);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_tdata", m_tdata, e.d);
                    chk("m_tlast", m_tlast, e.l);
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        t_first    = ncyc;
                    end
                    if (m_tlast) begin
                        gap_chk = 1'b1;
                        t_last  = ncyc;
                    end
                end
            end
        end
    end

    initial begin
        logic demux_addr;

        // Reset state.
        #12;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_grant", cur_grant, 0);
        chk("rst_m1_tvalid", m1_tvalid, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Single 3-beat packet from source 2.
        @(posedge aclk);
        #1;
        busy_cnt = 0;
        send_pkt(2, 3, 8'hA1);
        wait_drain(50);
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        chk("t1_busy_cycles", busy_cnt, 7);
        chk("t1_cur_grant", cur_grant, 2);
        chk("t1_busy", busy, 0);

        // All sources valid, two rounds of 2-beat packets.
        do_reset();
        first_seen = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < NUM; s++) begin
                send_pkt(s, 2, 8'(16 * s + 4 * r + 1));
            end
        end
        wait_drain(200);
        chk("t2_span", t_last - t_first, 54);
        chk("t2_cur_grant", cur_grant, 3);

        // Backpressure toggling 1010 through header and body.
        do_reset();
        send_pkt(1, 3, 8'h31);
        send_pkt(3, 2, 8'h71);
        for (int c = 0; c < 40; c++) begin
            m_tready = (c % 2 == 0);
            @(posedge aclk);
            #1;
        end
        m_tready = 1'b1;
        wait_drain(100);

        // Source 1 stalls 3 cycles mid-packet, source 2 waiting.
        do_reset();
        send_pkt(1, 4, 8'h41);
        send_pkt(2, 2, 8'h81);
        wait_sz(8, 100, "t4_reach_body2");
        hold[1] = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("t4_bubble", m_tvalid, 0);
            chk("t4_grant", cur_grant, 1);
        end
        @(posedge aclk);
        #1;
        hold[1] = 1'b0;
        wait_drain(100);

        // Reset during body beat 2, then sources 0 and 3 contend.
        do_reset();
        send_pkt(0, 4, 8'h51);
        wait_sz(3, 100, "t5_reach_body1");
        #2;
        chk("t5_pre_data", m_tdata, 8'h52);
        aresetn = 1'b0;
        #1;
        chk("t5_rst_valid", m_tvalid, 0);
        chk("t5_rst_data", m_tdata, 0);
        chk("t5_rst_last", m_tlast, 0);
        chk("t5_rst_ready", s_tready, 0);
        chk("t5_rst_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        send_pkt(0, 1, 8'hC0);
        send_pkt(3, 1, 8'hC3);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        wait_drain(60);
        chk("t5_cur_grant", cur_grant, 3);

        // HEAD_DUMMY=1, NUM=2: one beat from source 1, demux route check.
        @(posedge aclk);
        #1;
        s1_tdata  = 16'h5C00;
        s1_tlast  = 2'b10;
        s1_tvalid = 2'b10;
        @(negedge aclk);
        chk("t6_arb_cycle", m1_tvalid, 0);
        @(negedge aclk);
        chk("t6_hdr_valid", m1_tvalid, 1);
        chk("t6_hdr_data", m1_tdata, 8'h01);
        chk("t6_hdr_last", m1_tlast, 0);
        chk("t6_hdr_ready", s1_tready, 0);
        demux_addr = m1_tdata[0];
        @(negedge aclk);
        chk("t6_body_data", m1_tdata, 8'h5C);
        chk("t6_body_last", m1_tlast, 1);
        chk("t6_body_ready", s1_tready, 2'b10);
        chk("t6_demux_out", demux_addr, 1);
        @(posedge aclk);
        #1;
        s1_tvalid = '0;
        s1_tlast  = '0;
        @(negedge aclk);
        chk("t6_idle", busy1, 0);
        chk("t6_grant", cur_grant1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
